// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential increment, redirects, and redirects buffered behind stalls.
// Define PC_MISALIGN_CHECK_EN to trap misaligned redirect targets to TRAP_VECTOR.
module pc_sequencer #(
  parameter int               XLEN         = 32,
  parameter int               INC          = 4,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            pc_valid_o,
  output logic            pending_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_addr_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_tgt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_pend_nxt;
  logic [XLEN-1:0] w_pc_plus;
  logic [XLEN-1:0] w_apply_tgt;
  logic [XLEN-1:0] w_pc_d;
  logic            w_apply;
  logic            w_reject;

  // Truncating add gives the required modulo-2^XLEN wrap with no carry out.
  assign w_pc_plus = r_pc + XLEN'(INC);

  // w_apply marks the single point where a redirect target is about to be loaded,
  // so the optional alignment check sees both direct and released-pending redirects.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend_tgt;
    w_apply     = 1'b0;
    w_apply_tgt = redirect_target_i;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (!stall_i) begin
          if (redirect_valid_i) w_apply  = 1'b1;
          else                  w_pc_nxt = w_pc_plus;
        end else if (redirect_valid_i) begin
          w_pend_nxt  = redirect_target_i;
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (stall_i) begin
          if (redirect_valid_i) w_pend_nxt = redirect_target_i;
        end else begin
          w_apply     = 1'b1;
          w_apply_tgt = redirect_valid_i ? redirect_target_i : r_pend_tgt;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

`ifdef PC_MISALIGN_CHECK_EN
  assign w_reject = w_apply && (w_apply_tgt[1:0] != 2'b00);
`else
  assign w_reject = 1'b0;
`endif

  assign w_pc_d = w_reject ? TRAP_VECTOR :
                  w_apply  ? w_apply_tgt : w_pc_nxt;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VECTOR;
      r_pend_tgt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_d;
      r_pend_tgt <= w_pend_nxt;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic            r_misalign;
  logic [XLEN-1:0] r_bad_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
      r_bad_addr <= '0;
    end else begin
      r_misalign <= w_reject;
      if (w_reject) r_bad_addr <= w_apply_tgt;
    end
  end

  assign misalign_o = r_misalign;
  assign bad_addr_o = r_bad_addr;
`else
  assign misalign_o = 1'b0;
  assign bad_addr_o = '0;
`endif

  assign pc_o       = r_pc;
  assign pc_plus_o  = w_pc_plus;
  assign pc_valid_o = (r_state == S_RUN) || (r_state == S_PEND);
  assign pending_o  = (r_state == S_PEND);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run
// against a queue-based behavioural model of the fetch PC.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_o;
  logic        pc_valid_o;
  logic        pending_o;
  logic        misalign_o;
  logic [31:0] bad_addr_o;

  int n_checks;
  int n_fail;

`ifdef PC_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  pc_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .pc_o              (pc_o),
    .pc_plus_o         (pc_plus_o),
    .pc_valid_o        (pc_valid_o),
    .pending_o         (pending_o),
    .misalign_o        (misalign_o),
    .bad_addr_o        (bad_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given inputs; returns on the following falling edge.
  task automatic step(input logic s, input logic v, input logic [31:0] t);
    stall_i           = s;
    redirect_valid_i  = v;
    redirect_target_i = t;
    @(posedge clk);
    @(negedge clk);
    stall_i           = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_target_i = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
    n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", pc_valid_o); end
    n_checks++; if (pending_o !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", pending_o); end
    n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", misalign_o); end
    n_checks++; if (bad_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_bad_addr got=%h exp=0", bad_addr_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_seq [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    apply_reset();
    n_checks++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL seq_boot got pc=%h v=%b exp pc=0 v=0", pc_o, pc_valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0);
      n_checks++; if (pc_o !== exp_seq[i] || pc_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL seq_%0d got pc=%h v=%b exp pc=%h v=1", i, pc_o, pc_valid_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h10);
    n_checks++; if (pc_o !== 32'h10) begin n_fail++; $display("FAIL redir_setup got=%h exp=%h", pc_o, 32'h10); end
    step(1'b0, 1'b1, 32'h200);
    n_checks++; if (pc_o !== 32'h200) begin n_fail++; $display("FAIL redir_pc got=%h exp=%h", pc_o, 32'h200); end
    n_checks++; if (pc_plus_o !== 32'h204) begin n_fail++; $display("FAIL redir_plus got=%h exp=%h", pc_plus_o, 32'h204); end
  endtask

  task automatic test_stall_pending();
    apply_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h20);
    step(1'b1, 1'b1, 32'h300);
    n_checks++; if (pc_o !== 32'h20 || pending_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_c1 got pc=%h p=%b exp pc=20 p=1", pc_o, pending_o);
    end
    step(1'b1, 1'b1, 32'h400);
    n_checks++; if (pc_o !== 32'h20 || pending_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_c2 got pc=%h p=%b exp pc=20 p=1", pc_o, pending_o);
    end
    step(1'b1, 1'b0, '0);
    n_checks++; if (pc_o !== 32'h20 || pending_o !== 1'b1 || pc_plus_o !== 32'h24) begin
      n_fail++; $display("FAIL stall_c3 got pc=%h p=%b plus=%h exp pc=20 p=1 plus=24", pc_o, pending_o, pc_plus_o);
    end
    step(1'b0, 1'b0, '0);
    n_checks++; if (pc_o !== 32'h400 || pending_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_release got pc=%h p=%b exp pc=400 p=0", pc_o, pending_o);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    n_checks++; if (pc_plus_o !== 32'h0) begin n_fail++; $display("FAIL wrap_plus got=%h exp=0", pc_plus_o); end
    step(1'b0, 1'b0, '0);
    n_checks++; if (pc_o !== 32'h0 || misalign_o !== 1'b0) begin
      n_fail++; $display("FAIL wrap_pc got pc=%h m=%b exp pc=0 m=0", pc_o, misalign_o);
    end
  endtask

  task automatic test_misalign();
    apply_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h102);
    if (CHK) begin
      n_checks++; if (pc_o !== 32'h100 || misalign_o !== 1'b1 || bad_addr_o !== 32'h102) begin
        n_fail++; $display("FAIL misalign_trap got pc=%h m=%b bad=%h exp pc=100 m=1 bad=102", pc_o, misalign_o, bad_addr_o);
      end
      step(1'b0, 1'b0, '0);
      n_checks++; if (pc_o !== 32'h104 || misalign_o !== 1'b0 || bad_addr_o !== 32'h102) begin
        n_fail++; $display("FAIL misalign_after got pc=%h m=%b bad=%h exp pc=104 m=0 bad=102", pc_o, misalign_o, bad_addr_o);
      end
    end else begin
      n_checks++; if (pc_o !== 32'h102 || misalign_o !== 1'b0 || bad_addr_o !== 32'h0) begin
        n_fail++; $display("FAIL misalign_off got pc=%h m=%b bad=%h exp pc=102 m=0 bad=0", pc_o, misalign_o, bad_addr_o);
      end
    end
  endtask

  task automatic test_async_reset_pend();
    apply_reset();
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h500);
    n_checks++; if (pending_o !== 1'b1) begin n_fail++; $display("FAIL arst_setup got p=%b exp p=1", pending_o); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (pc_o !== 32'h0 || pending_o !== 1'b0 || pc_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL arst_immediate got pc=%h p=%b v=%b exp pc=0 p=0 v=0", pc_o, pending_o, pc_valid_o);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, '0);
    n_checks++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b1 || pending_o !== 1'b0) begin
      n_fail++; $display("FAIL arst_restart0 got pc=%h v=%b p=%b exp pc=0 v=1 p=0", pc_o, pc_valid_o, pending_o);
    end
    step(1'b0, 1'b0, '0);
    n_checks++; if (pc_o !== 32'h4) begin n_fail++; $display("FAIL arst_restart1 got pc=%h exp pc=4", pc_o); end
  endtask

  // Model: booted flag, PC, and a queue holding at most one deferred redirect target.
  task automatic test_random();
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_pend_q[$];
    logic        m_mis;
    logic [31:0] m_bad;
    logic        s, v, apply;
    logic [31:0] t, tgt;
    apply_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_pend_q.delete(); m_mis = 1'b0; m_bad = 32'h0;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 9) < 4);
      v = ($urandom_range(0, 9) < 3);
      t = $urandom();
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step(s, v, t);
      apply = 1'b0; tgt = '0; m_mis = 1'b0;
      if (!m_valid) begin
        m_valid = 1'b1;
      end else if (!s) begin
        if (m_pend_q.size() != 0) begin
          apply = 1'b1; tgt = v ? t : m_pend_q[0]; m_pend_q.delete();
        end else if (v) begin
          apply = 1'b1; tgt = t;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else if (v) begin
        m_pend_q.delete(); m_pend_q.push_back(t);
      end
      if (apply) begin
        if (CHK && tgt[1:0] != 2'b00) begin
          m_pc = 32'h100; m_mis = 1'b1; m_bad = tgt;
        end else begin
          m_pc = tgt;
        end
      end
      n_checks++; if (pc_o !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d] got=%h exp=%h", i, pc_o, m_pc); end
      n_checks++; if (pc_plus_o !== m_pc + 32'd4) begin n_fail++; $display("FAIL rand_plus[%0d] got=%h exp=%h", i, pc_plus_o, m_pc + 32'd4); end
      n_checks++; if (pc_valid_o !== m_valid) begin n_fail++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, pc_valid_o, m_valid); end
      n_checks++; if (pending_o !== (m_pend_q.size() != 0)) begin n_fail++; $display("FAIL rand_pending[%0d] got=%b exp=%b", i, pending_o, m_pend_q.size() != 0); end
      n_checks++; if (misalign_o !== m_mis) begin n_fail++; $display("FAIL rand_misalign[%0d] got=%b exp=%b", i, misalign_o, m_mis); end
      n_checks++; if (bad_addr_o !== m_bad) begin n_fail++; $display("FAIL rand_bad_addr[%0d] got=%h exp=%h", i, bad_addr_o, m_bad); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_pending();
    test_wrap();
    test_misalign();
    test_async_reset_pend();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
